// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the byte-lane helper used by both the FSM and the lane datapath.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Lowest byte lane touched by an access; halfwords start on lane 0 or 2.
    function automatic logic [1:0] lane_index(input logic [1:0] addr_lo, input logic [2:0] size);
        lane_index = (size[1:0] == 2'b01) ? {addr_lo[1], 1'b0} : addr_lo;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane datapath: extracts and extends load data, and merges
// sub-word store data into a word read from memory.
module lsu_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [1:0]  w_lane;
    logic [4:0]  w_bit_ofs;
    logic [31:0] w_shifted;

    always_comb begin
        w_lane    = lane_index(i_addr_lo, i_size);
        w_bit_ofs = {w_lane, 3'b000};
        w_shifted = i_word >> w_bit_ofs;

        o_load = i_word;
        case (i_size[1:0])
            2'b00:   o_load = i_size[2] ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   o_load = i_size[2] ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = i_word;
        endcase

        o_merged = i_word;
        case (i_size[1:0])
            2'b00:   o_merged[w_bit_ofs +: 8]  = i_wdata[7:0];
            2'b01:   o_merged[w_bit_ofs +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed memory with
// combinational reads and falling-edge writes; sub-word stores use RMW.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter bit RANGE_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data,
    output state_t      dbg_state
);

    // Handshake: req is taken on any rising edge where busy=0; every accepted
    // request yields exactly one done pulse (err qualified by done) unless rst
    // aborts it. The requester holds req while busy=1.

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;

    logic        w_misalign;
    logic        w_range;
    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    lsu_lane_unit u_lane (
        .i_word    (mem_read_data),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_misalign = 1'b0;
        case (size)
            SZ_B, SZ_BU: w_misalign = 1'b0;
            SZ_H, SZ_HU: w_misalign = addr[0];
            SZ_W:        w_misalign = (addr[1:0] != 2'b00);
            default:     w_misalign = 1'b1;
        endcase
        w_range = RANGE_CHECK && ((64'(addr[31:2]) >> MEM_DEPTH_LOG2) != 64'd0);
        w_fault = w_misalign || w_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_size  <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_merge <= 32'd0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_RD) || (r_state == ST_WR) || (r_state == ST_FAULT);
            r_err   <= (r_state == ST_FAULT);
            if (r_state == ST_IDLE && req) begin
                r_size  <= size;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == ST_RD)     r_rdata <= w_load;
            if (r_state == ST_RMW_RD) r_merge <= w_merged;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_fault)             w_next = ST_FAULT;
                    else if (!is_store)      w_next = ST_RD;
                    else if (size == SZ_W)   w_next = ST_WR;
                    else                     w_next = ST_RMW_RD;
                end
            end
            ST_RD:     w_next = ST_IDLE;
            ST_RMW_RD: w_next = ST_WR;
            ST_WR:     w_next = ST_IDLE;
            ST_FAULT:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Write strobe is gated by rst so a reset in WR kills the falling-edge write.
    always_comb begin
        busy           = (r_state != ST_IDLE);
        mem_read       = (r_state == ST_RD) || (r_state == ST_RMW_RD);
        mem_write      = (r_state == ST_WR) && !rst;
        mem_address    = busy ? {2'b00, r_addr[31:2]} : 32'd0;
        mem_write_data = 32'd0;
        if (r_state == ST_WR)
            mem_write_data = (r_size == SZ_W) ? r_wdata : r_merge;
    end

    assign rdata     = r_rdata;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a falling-edge-write memory model.
module tb_load_store_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  state_t      dbg_state;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;
  int          wr_cnt;

  load_store_unit #(.MEM_DEPTH_LOG2(8), .RANGE_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .is_store       (is_store),
    .size           (size),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:0]];

  always @(negedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with busy=0; returns #1 after the edge where done is seen.
  task automatic issue(input logic st, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int latency, output int writes);
    is_store = st; size = sz; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    latency = 1;
    writes = 0;
    while (!done && latency < 20) begin
      if (mem_write) writes++;
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[5] = 32'h8899AABB;
    mem[3] = 32'h11223344;
    mem[9] = 32'h01234567;
    rst = 1'b1; req = 1'b0; is_store = 1'b0; size = SZ_W; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, SZ_B, 32'h17, 32'd0, lat, wr_cnt);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_rdata", rdata, 32'hFFFFFF88);
    check("lb_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);

    issue(1'b0, SZ_BU, 32'h16, 32'd0, lat, wr_cnt);
    check("lbu_lat", 32'(lat), 32'd2);
    check("lbu_rdata", rdata, 32'h00000099);

    issue(1'b0, SZ_H, 32'h14, 32'd0, lat, wr_cnt);
    check("lh_rdata", rdata, 32'hFFFFAABB);

    issue(1'b0, SZ_HU, 32'h16, 32'd0, lat, wr_cnt);
    check("lhu_lat", 32'(lat), 32'd2);
    check("lhu_rdata", rdata, 32'h00008899);

    issue(1'b1, SZ_B, 32'h0D, 32'hFFFFFF5A, lat, wr_cnt);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_writes", 32'(wr_cnt), 32'd1);
    check("sb_err", 32'(err), 32'd0);
    check("sb_mem3", mem[3], 32'h11225A44);
    check("sb_rdata_held", rdata, 32'h00008899);

    issue(1'b1, SZ_W, 32'h12, 32'hCAFEF00D, lat, wr_cnt);
    check("sw_mis_lat", 32'(lat), 32'd2);
    check("sw_mis_err", 32'(err), 32'd1);
    check("sw_mis_writes", 32'(wr_cnt), 32'd0);
    check("sw_mis_mem4", mem[4], 32'd0);
    check("fault_rdata_held", rdata, 32'h00008899);

    issue(1'b0, SZ_H, 32'h21, 32'd0, lat, wr_cnt);
    check("lh_mis_err", 32'(err), 32'd1);
    issue(1'b0, 3'b011, 32'h0, 32'd0, lat, wr_cnt);
    check("reserved_err", 32'(err), 32'd1);
    issue(1'b0, SZ_W, 32'h400, 32'd0, lat, wr_cnt);
    check("range_err", 32'(err), 32'd1);
    check("range_lat", 32'(lat), 32'd2);

    issue(1'b1, SZ_W, 32'h20, 32'hDEADBEEF, lat, wr_cnt);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(err), 32'd0);
    check("sw_done_busy", 32'(busy), 32'd0);
    issue(1'b0, SZ_W, 32'h20, 32'd0, lat, wr_cnt);
    check("b2b_lw_lat", 32'(lat), 32'd2);
    check("b2b_lw_rdata", rdata, 32'hDEADBEEF);
    check("b2b_mem8", mem[8], 32'hDEADBEEF);

    // SH into word 9 with reset asserted during the WR cycle.
    is_store = 1'b1; size = SZ_H; addr = 32'h26; wdata = 32'h0000BEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("sh_rmw_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    check("sh_wr_strobe", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #0.1;
    check("sh_wr_gated", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr_mem9", mem[9], 32'h01234567);
    check("rstwr_done", 32'(done), 32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_rdata", rdata, 32'd0);
    check("rstwr_mem_address", mem_address, 32'd0);
    check("rstwr_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    check("rstwr_no_late_done", 32'(done), 32'd0);
    check("rstwr_mem9_after", mem[9], 32'h01234567);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
CPU-side initiator for the word-addressed data memory: the memory takes a word index and a 32-bit word, writes on the falling clock edge and reads combinationally. The block accepts byte, halfword and word load/store requests from the MEM stage and turns them into memory accesses. Sub-word stores use a read-modify-write. Loads are extracted and sign- or zero-extended. Each request gets a single done pulse; alignment and range faults are flagged on err.

Parameters:
MEM_DEPTH_LOG2, 8, log2 of memory depth in words.
RANGE_CHECK, 1, when 1, word index >= 2**MEM_DEPTH_LOG2 is a fault.

Ports:
clk  input  1  system clock, rising-edge logic.
rst  input  1  synchronous active-high reset.
req  input  1  request valid; sampled only when busy=0.
is_store  input  1  1=store, 0=load.
size  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others reserved.
addr  input  32  byte address.
wdata  input  32  store data; sub-word data in the low bits.
rdata  output  32  extended load result; valid while done=1, held until the next done.
done  output  1  one-cycle completion pulse.
err  output  1  fault flag; qualified by done.
busy  output  1  high while a request is in flight.
mem_address  output  32  word index {2'b00, addr[31:2]}.
mem_write_data  output  32  word driven to memory.
mem_write  output  1  memory write strobe; the write occurs at the falling edge of that cycle.
mem_read  output  1  memory read enable.
mem_read_data  input  32  combinational memory read word.

Behaviour:
- Reset: state IDLE; rdata=0, done=0, err=0, busy=0, mem_write=0, mem_read=0. mem_address and mem_write_data are 0.
- Byte lanes are little-endian: byte k occupies bits 8k+7:8k; halfword h occupies bits 16h+15:16h.
- States:
  - IDLE: accepts when req=1. Latches is_store, size, addr and wdata. Computes the fault condition:
    - size reserved, or
    - size W with addr[1:0]!=0, or
    - size H/HU with addr[0]!=0, or
    - range fault when RANGE_CHECK=1.
  - From IDLE:
    - fault -> FAULT
    - load -> RD
    - store W -> WR
    - store B/H -> RMW_RD
    - store with BU/HU is treated as B/H.
  - RD: mem_read=1. At the rising edge, rdata <= lane extracted from mem_read_data and extended (B/H sign-extend, BU/HU zero-extend). Then -> IDLE with done=1.
  - RMW_RD: mem_read=1. At the rising edge, merge_q <= mem_read_data with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Then -> WR.
  - WR: mem_write=1 and mem_write_data = merged word (sub-word) or wdata (SW). Then -> IDLE with done=1.
  - FAULT: no memory strobes. Then -> IDLE with done=1, err=1.
- done and err are registered one-cycle pulses, asserted in the IDLE cycle following completion. busy=0 in that cycle, so a new req is accepted back-to-back.
- Latency, request cycle to done high:
  - LW, LB, LH, LBU, LHU: 2 cycles.
  - SW: 2 cycles.
  - SB, SH: 3 cycles.
  - fault: 2 cycles.
- rdata changes only on a completed load; stores and faults leave it unchanged.
- mem_write is gated with !rst. A reset asserted during the WR cycle suppresses the falling-edge write and returns the FSM to IDLE at the next rising edge. Reset during RD or RMW_RD aborts the request with no done.
- mem_address is driven from latched addr in all non-IDLE states. Strobes are never asserted in IDLE.
- req while busy=1 is ignored; the requester holds it.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU
  - state encoding (IDLE, RD, RMW_RD, WR, FAULT)
  - a byte-lane index function.
- One natural combinational sub-module, lsu_lane_unit, holds both lane functions:
  - extract/extend for loads
  - merge for stores.
- The FSM stays in the top.

Test Plan:
- Memory word 5 = 32'h8899AABB; LB addr 0x17 -> rdata 32'hFFFFFF88, done at cycle 2; LBU addr 0x16 -> 32'h00000099.
- LH addr 0x14 on the same word -> 32'hFFFFAABB; LHU addr 0x16 -> 32'h00008899.
- Word 3 = 32'h11223344; SB addr 0x0D wdata 32'hFFFFFF5A -> word 3 = 32'h11225A44. Exactly one mem_write cycle, done at cycle 3.
- SW addr 0x12 -> done=1, err=1, mem_write never high, memory unchanged. LH addr 0x21 -> err=1. size 3'b011 -> err=1. Word index 256 (addr 0x400) with RANGE_CHECK=1 -> err=1.
- Back-to-back: SW 0x20 = 32'hDEADBEEF, then LW 0x20 issued in SW's done cycle -> rdata 32'hDEADBEEF two cycles later.
- rst asserted during the WR cycle of SH -> target word unchanged, no done, busy=0 the next cycle; all outputs equal their reset values.
